reg_file_8x8: RTL and testbench
===============================

# reg_file_8x8

Register file that feeds the 8-bit ALU: eight 8-bit general registers, two combinational read ports driving the ALU's DATA1/DATA2 operands, and one clocked write port that takes the ALU RESULT back in. Holds all architectural operand state of the CPU datapath. Writes are synchronous to CLK, reads are asynchronous, and clearing is a synchronous active-low reset.

## Interface
- WIDTH, 8, data width of each register, of IN, and of OUT1/OUT2.
- DEPTH, 8, number of registers.
- ADDR_W, 3, address width; must satisfy 2^ADDR_W == DEPTH.
- CLK  input  1  sole clock; all state changes on rising edge.
- RESET_N  input  1  synchronous, active-low; sampled on rising CLK edge.
- IN  input  WIDTH  write data (ALU RESULT).
- INADDRESS  input  ADDR_W  write register index.
- WRITE  input  1  write enable, active-high.
- OUT1ADDRESS  input  ADDR_W  read port 1 index.
- OUT2ADDRESS  input  ADDR_W  read port 2 index.
- OUT1  output  WIDTH  contents of register OUT1ADDRESS (ALU DATA1).
- OUT2  output  WIDTH  contents of register OUT2ADDRESS (ALU DATA2).
- WRITE_DONE  output  1  one-cycle pulse: a write committed on the previous edge.

## Operation
- Storage: DEPTH x WIDTH array; no hardwired-zero register; every index is writable.
- Write: on rising CLK with RESET_N=1 and WRITE=1, register[INADDRESS] <= IN. With WRITE=0 the array holds.
- Read: OUT1 = register[OUT1ADDRESS], OUT2 = register[OUT2ADDRESS]; purely combinational. Both ports may address the same register, and both then show the same value.
- Reset: on rising CLK with RESET_N=0, all registers <= 0 and WRITE_DONE <= 0. Reset beats a simultaneous WRITE; that write is discarded.
- WRITE_DONE: registered; set to 1 on an edge that committed a write, cleared on every other edge. Back-to-back writes hold it high continuously.
- Reset mid-operation: a reset edge between two writes leaves every register at 0 and WRITE_DONE=0. It has no other effect; the next non-reset write commits normally.
- Out-of-range addresses are impossible by the parameter constraint; no checking is done.

## Timing
- Write latency: 1 edge. The new value appears on OUT1/OUT2 immediately after the committing edge, when the read address matches.
- Read latency: combinational from address or array change. The model includes no # delays, and the ALU's own delays stand unchanged.
- Output reset values after the first reset edge: OUT1=0, OUT2=0, WRITE_DONE=0.
- Before the first reset edge, the array is X and outputs are undefined.
- Read and write to the same index in the same cycle:
  - Without bypass, OUT shows the old value until the edge, then the new value.
  - With bypass, see Configuration.

## Configuration
- REG_FILE_BYPASS_EN defined:
  - Write-to-read forwarding applies while RESET_N=1 and WRITE=1.
  - For each read port whose address equals INADDRESS, OUTx = IN combinationally, before the edge.
  - This allows a same-cycle consumer to see the pending write.
- REG_FILE_BYPASS_EN undefined:
  - No forwarding; OUTx always reflects stored contents.
  - Storage and WRITE_DONE behaviour are identical in both builds.

## Test plan
- Reset: drive RESET_N=0 for 1 edge after writing 8'hFF to r3 -> OUT1 (addr 3) = 8'h00, WRITE_DONE=0.
- Write/read all: write r0..r7 = 8'h10..8'h17 on consecutive edges -> WRITE_DONE high for 8 edges. Reading addr pairs (0,7), (3,3), (5,2) gives (10,17), (13,13), (15,12).
- Write disabled: WRITE=0, IN=8'hAA, INADDRESS=4 for 3 edges -> r4 unchanged at 8'h14, WRITE_DONE=0.
- Reset vs write: RESET_N=0 with WRITE=1, IN=8'h55, INADDRESS=1 -> r1=8'h00 after the edge, WRITE_DONE=0.
- Same-cycle read of write target: r2=8'h12; WRITE=1, IN=8'h99, INADDRESS=2, OUT2ADDRESS=2.
  - Before the edge: OUT2=8'h12 without bypass, 8'h99 with REG_FILE_BYPASS_EN.
  - After the edge: 8'h99 in both builds.
- ALU loop: r1=8'h08, r2=8'h01 feed the ALU with SELECT=001 (ADD). Write RESULT back to r3 -> OUT1 (addr 3) = 8'h09 after the edge.

Source files
------------

// File: rtl/reg_file_8x8.sv
// Eight-entry register file feeding the ALU: two async read ports, one sync write port.
// Optional write-to-read forwarding is enabled by defining REG_FILE_BYPASS_EN.
module reg_file_8x8 #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [WIDTH-1:0]  IN,
    input  logic [ADDR_W-1:0] INADDRESS,
    input  logic              WRITE,
    input  logic [ADDR_W-1:0] OUT1ADDRESS,
    input  logic [ADDR_W-1:0] OUT2ADDRESS,
    output logic [WIDTH-1:0]  OUT1,
    output logic [WIDTH-1:0]  OUT2,
    output logic              WRITE_DONE
);

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic             done_q;
    logic             done_d;

    always_comb begin
        regs_d = regs_q;
        done_d = WRITE;
        if (WRITE) begin
            regs_d[INADDRESS] = IN;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            regs_q <= '{default: '0};
            done_q <= 1'b0;
        end else begin
            regs_q <= regs_d;
            done_q <= done_d;
        end
    end

`ifdef REG_FILE_BYPASS_EN
    // A pending write is visible to same-cycle readers of the target index.
    logic fwd1;
    logic fwd2;

    assign fwd1 = RESET_N && WRITE && (OUT1ADDRESS == INADDRESS);
    assign fwd2 = RESET_N && WRITE && (OUT2ADDRESS == INADDRESS);
    assign OUT1 = fwd1 ? IN : regs_q[OUT1ADDRESS];
    assign OUT2 = fwd2 ? IN : regs_q[OUT2ADDRESS];
`else
    assign OUT1 = regs_q[OUT1ADDRESS];
    assign OUT2 = regs_q[OUT2ADDRESS];
`endif

    assign WRITE_DONE = done_q;

endmodule

// File: tb/tb_reg_file_8x8.sv
// Scoreboard bench for reg_file_8x8: a bench-side register model pushes expected
// read values into a queue; they are popped and compared after outputs settle.
module tb_reg_file_8x8;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b1;
    logic [7:0] IN = '0;
    logic [2:0] INADDRESS = '0;
    logic       WRITE = 1'b0;
    logic [2:0] OUT1ADDRESS = '0;
    logic [2:0] OUT2ADDRESS = '0;
    logic [7:0] OUT1;
    logic [7:0] OUT2;
    logic       WRITE_DONE;

    reg_file_8x8 dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .IN          (IN),
        .INADDRESS   (INADDRESS),
        .WRITE       (WRITE),
        .OUT1ADDRESS (OUT1ADDRESS),
        .OUT2ADDRESS (OUT2ADDRESS),
        .OUT1        (OUT1),
        .OUT2        (OUT2),
        .WRITE_DONE  (WRITE_DONE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string      tag;
        logic [7:0] v;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mdl [8];
    logic       mdone;
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock edge with the given controls; the model follows the same edge.
    task automatic cyc(input logic rst_n, input logic wr,
                       input logic [2:0] a, input logic [7:0] d);
        RESET_N   = rst_n;
        WRITE     = wr;
        INADDRESS = a;
        IN        = d;
        @(posedge CLK);
        if (!rst_n) begin
            foreach (mdl[i]) mdl[i] = 8'h00;
            mdone = 1'b0;
        end else begin
            if (wr) mdl[a] = d;
            mdone = wr;
        end
        #1;
        WRITE   = 1'b0;
        RESET_N = 1'b1;
    endtask

    task automatic rd(input string tag, input logic [2:0] a1,
                      input logic [2:0] a2);
        exp_t e;
        OUT1ADDRESS = a1;
        OUT2ADDRESS = a2;
        sb.push_back('{{tag, "_o1"}, mdl[a1]});
        sb.push_back('{{tag, "_o2"}, mdl[a2]});
        sb.push_back('{{tag, "_wd"}, {7'b0, mdone}});
        #1;
        e = sb.pop_front();
        check(e.tag, OUT1, e.v);
        e = sb.pop_front();
        check(e.tag, OUT2, e.v);
        e = sb.pop_front();
        check(e.tag, {7'b0, WRITE_DONE}, e.v);
    endtask

    initial begin
        exp_t e;
        #2;
        cyc(1'b0, 1'b0, 3'd0, 8'h00);
        rd("rst0", 3'd0, 3'd7);

        // Reset after a write clears the written register.
        cyc(1'b1, 1'b1, 3'd3, 8'hFF);
        rd("pre_rst", 3'd3, 3'd3);
        check("pre_rst_ff", OUT1, 8'hFF);
        cyc(1'b0, 1'b0, 3'd0, 8'h00);
        rd("rst", 3'd3, 3'd3);
        check("rst_r3", OUT1, 8'h00);

        // Back-to-back writes keep WRITE_DONE high every edge.
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b1, 3'(i), 8'h10 + 8'(i));
            rd($sformatf("wr%0d", i), 3'(i), 3'(i));
        end
        rd("p07", 3'd0, 3'd7);
        check("p07_c", OUT2, 8'h17);
        rd("p33", 3'd3, 3'd3);
        rd("p52", 3'd5, 3'd2);
        check("p52_c", OUT1, 8'h15);

        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 3'd4, 8'hAA);
            rd($sformatf("wdis%0d", i), 3'd4, 3'd0);
        end
        check("wdis_r4", OUT1, 8'h14);

        cyc(1'b0, 1'b1, 3'd1, 8'h55);
        rd("rstwr", 3'd1, 3'd2);
        check("rstwr_r1", OUT1, 8'h00);

        // Same-cycle read of the write target, before and after the edge.
        cyc(1'b1, 1'b1, 3'd2, 8'h12);
        rd("r2set", 3'd0, 3'd2);
        WRITE       = 1'b1;
        IN          = 8'h99;
        INADDRESS   = 3'd2;
        OUT2ADDRESS = 3'd2;
`ifdef REG_FILE_BYPASS_EN
        sb.push_back('{"same_pre", 8'h99});
`else
        sb.push_back('{"same_pre", 8'h12});
`endif
        #1;
        e = sb.pop_front();
        check(e.tag, OUT2, e.v);
        @(posedge CLK);
        mdl[2] = 8'h99;
        mdone  = 1'b1;
        #1;
        WRITE = 1'b0;
        rd("same_post", 3'd0, 3'd2);

        // ALU loop: ADD of r1 and r2 written back into r3.
        cyc(1'b1, 1'b1, 3'd1, 8'h08);
        cyc(1'b1, 1'b1, 3'd2, 8'h01);
        rd("alu_src", 3'd1, 3'd2);
        cyc(1'b1, 1'b1, 3'd3, mdl[1] + mdl[2]);
        rd("alu_wb", 3'd3, 3'd1);
        check("alu_r3", OUT1, 8'h09);

        cyc(1'b1, 1'b0, 3'd0, 8'h00);
        rd("idle", 3'd3, 3'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
